uart_baud_gen: RTL and testbench
================================

UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 SHALL have parameter OVERSAMPLE, 16, rx ticks per bit; legal values 4, 8, 16.
REQ-002 SHALL have parameter DIV_W, 16, width of integer divisor.
REQ-003 SHALL have parameter FRAC_W, 8, width of fractional divisor.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port arst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port active  input  1  enable; low holds generator idle and cleared.
REQ-007 SHALL have port div_int  input  DIV_W  integer clk cycles per rx tick.
REQ-008 SHALL have port div_frac  input  FRAC_W  fractional cycles per rx tick, in units of 2^-FRAC_W.
REQ-009 SHALL have port div_load  input  1  one-cycle strobe capturing div_int/div_frac into shadow registers.
REQ-010 SHALL have port rx_sync  input  1  one-cycle strobe realigning rx bit phase (start-bit edge).
REQ-011 SHALL have port rx_clk_en  output  1  one-cycle pulse at OVERSAMPLE x baud.
REQ-012 SHALL have port tx_clk_en  output  1  one-cycle pulse at 1x baud.
REQ-013 SHALL have port rx_mid_en  output  1  one-cycle pulse at mid-bit sample point.
REQ-014 SHALL have port cfg_err  output  1  level; active divisor illegal (div_int < 2).

Function
REQ-015 Divider SHALL count clk cycles while active=1; period ends with one rx_clk_en pulse, registered, single cycle.
REQ-016 Period length SHALL be div_int cycles, or div_int+1 when the carry flag from the previous tick is set.
REQ-017 On each rx_clk_en, FRAC_W-bit accumulator SHALL update acc = acc + div_frac mod 2^FRAC_W; carry-out sets next period to div_int+1.
REQ-018 First rx_clk_en after active rises SHALL occur in the div_int-th cycle with active high (acc=0, no carry).
REQ-019 tx_clk_en SHALL assert in the same cycle as every OVERSAMPLE-th rx_clk_en, counted by a free-running tx phase counter 0..OVERSAMPLE-1; first tx_clk_en coincides with the OVERSAMPLE-th rx_clk_en after active rises.
REQ-020 rx phase counter SHALL clear to 0 on rx_sync and increment mod OVERSAMPLE on each rx_clk_en.
REQ-021 rx_mid_en SHALL assert with the rx_clk_en that moves rx phase from OVERSAMPLE/2-1 to OVERSAMPLE/2, i.e. the OVERSAMPLE/2-th tick after rx_sync, then every OVERSAMPLE ticks.
REQ-022 rx_sync coincident with rx_clk_en: sync wins, that tick does not advance rx phase, and rx_mid_en stays 0.
REQ-023 rx_sync SHALL NOT affect divider count, accumulator, or tx phase.
REQ-024 div_load with active=0 SHALL update shadow divisor in the next cycle.
REQ-025 div_load with active=1 SHALL set a pending flag; shadow updates at the next rx_clk_en and governs the following period; a second div_load before then overwrites pending values.
REQ-026 Shadow div_int < 2 SHALL set cfg_err=1 and suppress all three pulse outputs; counters held at 0 until a legal load.
REQ-027 active falling SHALL, in the next cycle, clear divider count, accumulator, carry, tx and rx phase, and force outputs to 0; pending load SHALL be applied immediately.
REQ-028 Counter widths: divider DIV_W+1 bits; phase counters $clog2(OVERSAMPLE) bits; no overflow for any legal divisor.

Reset
REQ-029 arst_n low SHALL asynchronously clear all counters, accumulator, carry, pending flag, rx_clk_en, tx_clk_en, rx_mid_en.
REQ-030 Reset SHALL load shadow div_int=27, div_frac=32 (115200 baud at 50 MHz, OVERSAMPLE 16); cfg_err=0.
REQ-031 Reset deassertion mid-operation SHALL restart as REQ-018 when active=1.

Structure
REQ-032 Shared package uart_pkg SHALL hold OVERSAMPLE/DIV_W/FRAC_W defaults, CLOCK_FREQUENCY, and reset divisor constants.
REQ-033 Fractional divider (REQ-015..018, 025) SHALL be sub-module uart_frac_div, emitting the rx tick; phase logic remains in uart_baud_gen.

Verification
REQ-034 Reset, active=1, default divisor -> first rx_clk_en in cycle 27; first tx_clk_en with 16th rx tick.
REQ-035 FRAC_W=8, load div_int=4, div_frac=128 -> rx tick intervals 4,4,5,4,5,...; mean 4.5 over 64 ticks.
REQ-036 rx_sync mid-bit, OVERSAMPLE=16 -> rx_mid_en on 8th rx tick after sync, then every 16; tx_clk_en spacing unchanged.
REQ-037 rx_sync in same cycle as rx_clk_en -> rx_mid_en on 8th subsequent tick, not 7th.
REQ-038 Load div_int=1 -> cfg_err=1, no pulses; load div_int=10 -> cfg_err=0, ticks every 10 cycles.
REQ-039 div_load while active mid-period -> current period length unchanged, new divisor from next period; active drop mid-period -> all outputs 0 next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART baud generator: parameter defaults, the board
// clock, and the divisor loaded at reset (115200 baud at 50 MHz, 16x oversampling).
package uart_pkg;

  localparam int OVERSAMPLE_DEF  = 16;
  localparam int DIV_W_DEF       = 16;
  localparam int FRAC_W_DEF      = 8;
  localparam int CLOCK_FREQUENCY = 50_000_000;

  // 50e6 / (115200 * 16) = 27.126 -> 27 + 32/256
  localparam int RESET_DIV_INT   = 27;
  localparam int RESET_DIV_FRAC  = 32;

  // Divisors below this cannot produce a one-cycle pulse followed by a gap.
  localparam int MIN_DIV_INT     = 2;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control/strobe bundle between a UART core (master) and the baud generator (slave).
interface uart_baud_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 8
) ();

  // All strobes are single-cycle and sampled on the rising clock edge; there is
  // no back-pressure: div_load and rx_sync are always accepted, and the three
  // *_en outputs are one-cycle pulses the consumer must act on in that cycle.
  logic              active;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              rx_sync;
  logic              rx_clk_en;
  logic              tx_clk_en;
  logic              rx_mid_en;
  logic              cfg_err;

  modport master (
    output active, div_int, div_frac, div_load, rx_sync,
    input  rx_clk_en, tx_clk_en, rx_mid_en, cfg_err
  );

  modport slave (
    input  active, div_int, div_frac, div_load, rx_sync,
    output rx_clk_en, tx_clk_en, rx_mid_en, cfg_err
  );

endinterface

// File: rtl/uart_frac_div.sv
// Fractional clock divider: emits the oversampling tick every div_int or
// div_int+1 cycles, steered by a first-order fractional accumulator.
module uart_frac_div
  import uart_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              active_i,
  input  logic              div_load_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              tick_d_o,
  output logic              tick_o,
  output logic              run_o,
  output logic              cfg_err_o
);

  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic              tick_q;
  logic              pend_q, pend_d;
  logic [DIV_W-1:0]  pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic [DIV_W-1:0]  shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;

  logic              legal;
  logic              run;
  logic              tick_d;
  logic [DIV_W:0]    period;
  logic [FRAC_W:0]   acc_sum;

  always_comb begin
    legal   = (shd_int_q >= DIV_W'(MIN_DIV_INT));
    run     = active_i & legal;
    period  = {1'b0, shd_int_q} + {{DIV_W{1'b0}}, carry_q};
    tick_d  = run & (cnt_q == (period - (DIV_W+1)'(1)));
    acc_sum = {1'b0, acc_q} + {1'b0, shd_frac_q};

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    pend_d      = pend_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    shd_int_d   = shd_int_q;
    shd_frac_d  = shd_frac_q;

    if (run) begin
      if (tick_d) begin
        // The fraction in force for the ending period feeds the carry; a pending
        // divisor takes over from the next period onward.
        cnt_d   = '0;
        acc_d   = acc_sum[FRAC_W-1:0];
        carry_d = acc_sum[FRAC_W];
        if (pend_q) begin
          shd_int_d  = pend_int_q;
          shd_frac_d = pend_frac_q;
          pend_d     = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + (DIV_W+1)'(1);
      end
      if (div_load_i) begin
        pend_d      = 1'b1;
        pend_int_d  = div_int_i;
        pend_frac_d = div_frac_i;
      end
    end else begin
      // Idle or illegal divisor: hold cleared and let loads land directly so a
      // bad divisor can always be replaced.
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      pend_d  = 1'b0;
      if (div_load_i) begin
        shd_int_d  = div_int_i;
        shd_frac_d = div_frac_i;
      end else if (pend_q) begin
        shd_int_d  = pend_int_q;
        shd_frac_d = pend_frac_q;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      tick_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      shd_int_q   <= DIV_W'(RESET_DIV_INT);
      shd_frac_q  <= FRAC_W'(RESET_DIV_FRAC);
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      shd_int_q   <= shd_int_d;
      shd_frac_q  <= shd_frac_d;
    end
  end

  assign tick_d_o  = tick_d;
  assign tick_o    = tick_q;
  assign run_o     = run;
  assign cfg_err_o = ~legal;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: fractional rx oversampling tick plus tx (1x) and
// mid-bit strobes derived from free-running and resynchronisable phase counters.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int FRAC_W     = FRAC_W_DEF
) (
  input  logic            clk,
  input  logic            arst_n,
  uart_baud_gen_if.slave  bus
);

  localparam int               PH_W       = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_PRE_MID = PH_W'(OVERSAMPLE / 2 - 1);

  logic            tick_d;
  logic            tick_q;
  logic            run;
  logic            cfg_err;

  logic [PH_W-1:0] tx_ph_q, tx_ph_d;
  logic [PH_W-1:0] rx_ph_q, rx_ph_d;
  logic            tx_en_q, tx_en_d;
  logic            mid_q, mid_d;

  uart_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clk        (clk),
    .arst_n     (arst_n),
    .active_i   (bus.active),
    .div_load_i (bus.div_load),
    .div_int_i  (bus.div_int),
    .div_frac_i (bus.div_frac),
    .tick_d_o   (tick_d),
    .tick_o     (tick_q),
    .run_o      (run),
    .cfg_err_o  (cfg_err)
  );

  // rx_sync is sampled on the same edge that raises rx_clk_en; when both land
  // together the sync wins and that tick does not count toward mid-bit.
  always_comb begin
    tx_ph_d = tx_ph_q;
    rx_ph_d = rx_ph_q;
    tx_en_d = 1'b0;
    mid_d   = 1'b0;
    if (!run) begin
      tx_ph_d = '0;
      rx_ph_d = '0;
    end else begin
      if (tick_d) begin
        tx_en_d = (tx_ph_q == PH_LAST);
        tx_ph_d = (tx_ph_q == PH_LAST) ? '0 : tx_ph_q + PH_W'(1);
      end
      if (bus.rx_sync) begin
        rx_ph_d = '0;
      end else if (tick_d) begin
        mid_d   = (rx_ph_q == PH_PRE_MID);
        rx_ph_d = (rx_ph_q == PH_LAST) ? '0 : rx_ph_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_ph_q <= '0;
      rx_ph_q <= '0;
      tx_en_q <= 1'b0;
      mid_q   <= 1'b0;
    end else begin
      tx_ph_q <= tx_ph_d;
      rx_ph_q <= rx_ph_d;
      tx_en_q <= tx_en_d;
      mid_q   <= mid_d;
    end
  end

  assign bus.rx_clk_en = tick_q;
  assign bus.tx_clk_en = tx_en_q;
  assign bus.rx_mid_en = mid_q;
  assign bus.cfg_err   = cfg_err;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: divisor interval table plus hand-written
// sequences for reset, sync/mid-bit, illegal divisor and load/active corners.
module tb_uart_baud_gen;

  logic clk = 1'b0;
  logic arst_n;

  always #5 clk = ~clk;

  uart_baud_gen_if #(.DIV_W(16), .FRAC_W(8)) bus ();

  uart_baud_gen #(
    .OVERSAMPLE (16),
    .DIV_W      (16),
    .FRAC_W     (8)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  typedef struct {
    int div_int;
    int div_frac;
    int iv [6];
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until rx_clk_en is seen; returns the number of edges taken, -1 on timeout.
  task automatic wait_rx(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.rx_clk_en !== 1'b1 && n < 300);
    if (bus.rx_clk_en !== 1'b1) n = -1;
  endtask

  task automatic load_idle(input int di, input int df);
    bus.active   = 1'b0;
    bus.div_int  = 16'(di);
    bus.div_frac = 8'(df);
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
    step();
  endtask

  task automatic add_vec(input int di, input int df, input int a, input int b,
                         input int c, input int d, input int e, input int f);
    vec_t v;
    v.div_int  = di;
    v.div_frac = df;
    v.iv[0] = a; v.iv[1] = b; v.iv[2] = c;
    v.iv[3] = d; v.iv[4] = e; v.iv[5] = f;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, sum, pulses, nm, nt, bad;
    int mid_t[4];
    int tx_c[4];
    int tx_at;

    add_vec(27, 32,  27, 27, 27, 27, 27, 27);
    add_vec(4,  128, 4,  4,  5,  4,  5,  4);
    add_vec(10, 0,   10, 10, 10, 10, 10, 10);
    add_vec(2,  255, 2,  2,  3,  3,  3,  3);
    add_vec(3,  64,  3,  3,  3,  3,  4,  3);
    add_vec(5,  192, 5,  5,  6,  6,  6,  5);

    // Reset with active already high.
    arst_n       = 1'b0;
    bus.active   = 1'b1;
    bus.div_int  = '0;
    bus.div_frac = '0;
    bus.div_load = 1'b0;
    bus.rx_sync  = 1'b0;
    repeat (3) step();
    check("reset_rx_clk_en", bus.rx_clk_en, 0);
    check("reset_tx_clk_en", bus.tx_clk_en, 0);
    check("reset_rx_mid_en", bus.rx_mid_en, 0);
    check("reset_cfg_err",   bus.cfg_err,   0);
    arst_n = 1'b1;

    wait_rx(n);
    check("first_rx_default", n, 27);
    t     = 1;
    tx_at = (bus.tx_clk_en === 1'b1) ? 1 : 0;
    while (t < 16) begin
      wait_rx(n);
      t++;
      if (bus.tx_clk_en === 1'b1 && tx_at == 0) tx_at = t;
    end
    check("first_tx_on_16th_rx", tx_at, 16);

    // Asynchronous reset mid-operation, then restart.
    wait_rx(n);
    arst_n = 1'b0;
    #1;
    check("async_reset_clears_rx", bus.rx_clk_en, 0);
    step();
    arst_n = 1'b1;
    wait_rx(n);
    check("restart_after_reset", n, 27);

    // Interval table.
    foreach (vecs[i]) begin
      load_idle(vecs[i].div_int, vecs[i].div_frac);
      bus.active = 1'b1;
      for (int k = 0; k < 6; k++) exp_q.push_back(32'(vecs[i].iv[k]));
      for (int k = 0; k < 6; k++) begin
        logic [31:0] e;
        wait_rx(n);
        e = exp_q.pop_front();
        check($sformatf("interval_div%0d_frac%0d_k%0d", vecs[i].div_int, vecs[i].div_frac, k),
              n, e);
      end
    end

    // 4.5 cycles per tick on average once the first period is past.
    load_idle(4, 128);
    bus.active = 1'b1;
    wait_rx(n);
    sum = 0;
    repeat (64) begin
      wait_rx(n);
      sum += n;
    end
    check("frac_64_interval_sum", sum, 288);

    // rx_sync mid-period.
    load_idle(10, 0);
    bus.active = 1'b1;
    repeat (3) wait_rx(n);
    repeat (3) step();
    bus.rx_sync = 1'b1;
    step();
    bus.rx_sync = 1'b0;
    t = 0; nm = 0; nt = 0; bad = 0;
    mid_t = '{-1, -1, -1, -1};
    tx_c  = '{-1000, -1000, -1000, -1000};
    for (int cyc = 1; cyc <= 400; cyc++) begin
      step();
      if (bus.rx_clk_en === 1'b1) t++;
      if (bus.rx_mid_en === 1'b1) begin
        if (bus.rx_clk_en !== 1'b1) bad++;
        if (nm < 4) mid_t[nm] = t;
        nm++;
      end
      if (bus.tx_clk_en === 1'b1) begin
        if (nt < 4) tx_c[nt] = cyc;
        nt++;
      end
    end
    check("mid_first_after_sync",  mid_t[0], 8);
    check("mid_second_after_sync", mid_t[1], 24);
    check("mid_only_with_rx_tick", bad, 0);
    check("tx_spacing_after_sync", tx_c[1] - tx_c[0], 160);

    // rx_sync landing on the tick that would have been mid-bit.
    wait_rx(n);
    step();
    step();
    bus.rx_sync = 1'b1;
    step();
    bus.rx_sync = 1'b0;
    repeat (7) wait_rx(n);
    repeat (9) step();
    bus.rx_sync = 1'b1;
    step();
    bus.rx_sync = 1'b0;
    check("coincident_tick_present", bus.rx_clk_en, 1);
    check("coincident_no_mid",       bus.rx_mid_en, 0);
    t = 0;
    do begin
      wait_rx(n);
      t++;
    end while (bus.rx_mid_en !== 1'b1 && t < 30);
    check("coincident_mid_on_8th", t, 8);

    // Illegal divisor loaded while running, then recovered.
    bus.div_int  = 16'd1;
    bus.div_frac = 8'd0;
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
    wait_rx(n);
    step();
    check("cfg_err_set", bus.cfg_err, 1);
    pulses = 0;
    repeat (60) begin
      step();
      if (bus.rx_clk_en === 1'b1 || bus.tx_clk_en === 1'b1 || bus.rx_mid_en === 1'b1) pulses++;
    end
    check("cfg_err_no_pulses", pulses, 0);
    bus.div_int  = 16'd10;
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
    check("cfg_err_cleared", bus.cfg_err, 0);
    wait_rx(n);
    check("legal_first_interval", n, 10);
    wait_rx(n);
    check("legal_second_interval", n, 10);

    // Load mid-period: current period keeps its length.
    repeat (3) step();
    bus.div_int  = 16'd6;
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
    wait_rx(n);
    check("load_mid_current_period", n, 6);
    wait_rx(n);
    check("load_mid_new_period", n, 6);

    // Drop active on the edge that would have produced a tick.
    repeat (5) step();
    bus.active = 1'b0;
    step();
    check("drop_rx_clk_en", bus.rx_clk_en, 0);
    check("drop_tx_clk_en", bus.tx_clk_en, 0);
    check("drop_rx_mid_en", bus.rx_mid_en, 0);
    bus.active = 1'b1;
    wait_rx(n);
    check("restart_after_active_drop", n, 6);

    // Pending load applied when active falls.
    step();
    step();
    bus.div_int  = 16'd7;
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
    bus.active   = 1'b0;
    step();
    bus.active   = 1'b1;
    wait_rx(n);
    check("pending_applied_on_drop", n, 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
